// File: rtl/bs_sequencer_pkg.sv
// Shared codes for the Black-Scholes sequencer: FSM/status encoding, host
// command values and default datapath geometry.
package bs_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ISSUE    = 4'd1,
    ST_COMPLETE = 4'd2,
    ST_DRAIN    = 4'd3
  } state_e;

  localparam logic [3:0] CMD_RUN = 4'd1;
  localparam logic [3:0] CMD_ACK = 4'd2;

  // 5+17+5+7+5 cycles through the floating-point datapath.
  localparam int PIPE_LAT_DEFAULT = 39;
  localparam int CNT_W_DEFAULT    = 16;

endpackage

// File: rtl/bs_sequencer_if.sv
// Host/datapath-facing bundle of the sequencer: commands in, status and
// issue/retire strobes out.
interface bs_sequencer_if #(
  parameter int CNT_W = 16
) ();

  logic [3:0]       cmd;
  logic [CNT_W-1:0] num_samples;
  logic             hold;
  logic [3:0]       status;
  logic             cfg_load;
  logic             issue_valid;
  logic [CNT_W-1:0] issue_idx;
  logic             result_valid;
  logic [CNT_W-1:0] result_idx;

  modport master (
    output cmd, num_samples, hold,
    input  status, cfg_load, issue_valid, issue_idx, result_valid, result_idx
  );

  modport slave (
    input  cmd, num_samples, hold,
    output status, cfg_load, issue_valid, issue_idx, result_valid, result_idx
  );

endinterface

// File: rtl/bs_valid_pipe.sv
// Fixed-depth valid shift register mirroring datapath latency; a bit entering
// in cycle C appears on dout in cycle C+DEPTH.
module bs_valid_pipe #(
  parameter int DEPTH = 39
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;

  always_comb begin
    shift_d    = shift_q;
    shift_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      shift_d[i] = shift_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign dout = shift_q[DEPTH-1];

endmodule

// File: rtl/bs_sequencer.sv
// Sample sequencer for the Black-Scholes datapath: accepts RUN, issues N
// samples (stallable by hold), tracks their results and waits for ACK.
module bs_sequencer
  import bs_sequencer_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  bs_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             run_accept;
  logic             issue_fire;
  logic             retire_fire;
  logic             pipe_out;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    issued_d    = issued_q;
    retired_d   = retired_q;
    run_accept  = 1'b0;
    issue_fire  = 1'b0;
    // Retire is state-independent: with N > PIPE_LAT results emerge mid-ISSUE.
    retire_fire = pipe_out && (retired_q < n_q);
    if (retire_fire) begin
      retired_d = retired_q + ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd == CMD_RUN) begin
          run_accept = 1'b1;
          n_d        = bus.num_samples;
          issued_d   = '0;
          retired_d  = '0;
          state_d    = (bus.num_samples == '0) ? ST_COMPLETE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.hold && (issued_q < n_q)) begin
          issue_fire = 1'b1;
          issued_d   = issued_q + ONE;
          if ((issued_q + ONE) == n_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (retire_fire && (retired_q == (n_q - ONE))) begin
          state_d = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        if (bus.cmd == CMD_ACK) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      issued_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
    end
  end

  bs_valid_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_valid_pipe (
    .clk  (clk),
    .clr  (reset),
    .din  (issue_fire),
    .dout (pipe_out)
  );

  assign bus.status       = state_q;
  assign bus.cfg_load     = run_accept;
  assign bus.issue_valid  = issue_fire;
  assign bus.issue_idx    = issued_q;
  assign bus.result_valid = pipe_out;
  assign bus.result_idx   = retired_q;

endmodule
